// File: rtl/gf12_sram64_be_sched_if.sv
// Requester-side handshake bundle for the GF12 SRAM bank-conflict scheduler.
// Carries write/read request channels and the read response channel.
interface gf12_sram64_be_sched_if #(
   parameter int ABITS  = 15,
   parameter int DWIDTH = 64
);
   logic              wr_valid;
   logic              wr_ready;
   logic [ABITS-1:0]  wr_addr;
   logic [DWIDTH-1:0] wr_data;
   logic [DWIDTH-1:0] wr_mask;
   logic              rd_valid;
   logic              rd_ready;
   logic [ABITS-1:0]  rd_addr;
   logic              rsp_valid;
   logic [DWIDTH-1:0] rsp_data;

   modport master (
      output wr_valid, wr_addr, wr_data, wr_mask,
      output rd_valid, rd_addr,
      input  wr_ready, rd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, wr_mask,
      input  rd_valid, rd_addr,
      output wr_ready, rd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/gf12_sram64_be_sched.sv
// Write-buffering bank-conflict scheduler in front of the 4-bank GF12 SRAM.
// Writes drain from a FIFO only when their bank is not hit by the current read.
module gf12_sram64_be_sched #(
   parameter int ABITS      = 15,
   parameter int DWIDTH     = 64,
   parameter int BANK_LSB   = 13,
   parameter int WBUF_DEPTH = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                CLK,
   input  logic                RSTN,
   gf12_sram64_be_sched_if.slave req,
   output logic                CE0,
   output logic [ABITS-1:0]    A0,
   output logic [DWIDTH-1:0]   D0,
   output logic                WE0,
   output logic [DWIDTH-1:0]   WEM0,
   output logic                CE1,
   output logic [ABITS-1:0]    A1,
   input  logic [DWIDTH-1:0]   Q1
);

   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int BW = ABITS - BANK_LSB;

   logic [ABITS-1:0]  r_addr [WBUF_DEPTH];
   logic [DWIDTH-1:0] r_data [WBUF_DEPTH];
   logic [DWIDTH-1:0] r_mask [WBUF_DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_cnt;
   logic [SW-1:0]     r_starve;
   logic              r_live;
   logic              r_rsp_valid;
   logic [DWIDTH-1:0] r_rsp_hold;

   logic              w_head_v;
   logic [BW-1:0]     w_hbank;
   logic [BW-1:0]     w_rbank;
   logic              w_hazard;
   logic              w_force;
   logic              w_rd_fire;
   logic              w_wr_fire;
   logic              w_issue;
   logic [PW-1:0]     w_off [WBUF_DEPTH];

   assign w_head_v = (r_cnt != '0);
   assign w_hbank  = r_addr[r_rptr][ABITS-1:BANK_LSB];
   assign w_rbank  = req.rd_addr[ABITS-1:BANK_LSB];

   // Entry j is live when its distance from the head is below the count.
   always_comb begin
      w_hazard = 1'b0;
      for (int j = 0; j < WBUF_DEPTH; j++) begin
         w_off[j] = PW'(j) - r_rptr;
         if (({1'b0, w_off[j]} < r_cnt) &&
             (r_addr[j] == req.rd_addr))
            w_hazard = 1'b1;
      end
   end

   assign w_force = w_head_v &
                    (r_starve == SW'(STARVE_MAX)) &
                    (w_hbank == w_rbank);

   assign req.wr_ready = (r_cnt < CW'(WBUF_DEPTH));
   assign req.rd_ready = r_live & ~w_hazard & ~w_force;

   assign w_wr_fire = req.wr_valid & req.wr_ready;
   assign w_rd_fire = req.rd_valid & req.rd_ready;
   assign w_issue   = w_head_v &
                      (~w_rd_fire | (w_hbank != w_rbank));

   assign CE0  = w_issue;
   assign WE0  = w_issue;
   assign A0   = w_issue ? r_addr[r_rptr] : '0;
   assign D0   = w_issue ? r_data[r_rptr] : '0;
   assign WEM0 = w_issue ? r_mask[r_rptr] : '0;
   assign CE1  = w_rd_fire;
   assign A1   = w_rd_fire ? req.rd_addr : '0;

   // Q1 is only meaningful in the cycle after a read; hold it otherwise.
   assign req.rsp_valid = r_rsp_valid;
   assign req.rsp_data  = r_rsp_valid ? Q1 : r_rsp_hold;

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         for (int i = 0; i < WBUF_DEPTH; i++) begin
            r_addr[i] <= '0;
            r_data[i] <= '0;
            r_mask[i] <= '0;
         end
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_cnt       <= '0;
         r_starve    <= '0;
         r_live      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_hold  <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_wr_fire) begin
            r_addr[r_wptr] <= req.wr_addr;
            r_data[r_wptr] <= req.wr_data;
            r_mask[r_wptr] <= req.wr_mask;
            r_wptr         <= r_wptr + PW'(1);
         end
         if (w_issue)
            r_rptr <= r_rptr + PW'(1);
         r_cnt <= r_cnt + CW'(w_wr_fire) - CW'(w_issue);
         if (!w_head_v || w_issue)
            r_starve <= '0;
         else if (r_starve != SW'(STARVE_MAX))
            r_starve <= r_starve + SW'(1);
         r_rsp_valid <= w_rd_fire;
         if (r_rsp_valid)
            r_rsp_hold <= Q1;
      end
   end

endmodule

// File: tb/tb_gf12_sram64_be_sched.sv
// Scoreboard bench for gf12_sram64_be_sched with an in-bench SRAM model.
// Reference view of memory = committed array plus the ordered pending writes.
module tb_gf12_sram64_be_sched;

   localparam int AW      = 15;
   localparam int DW      = 64;
   localparam int BL      = 13;
   localparam int DEPTH   = 4;
   localparam int SMAX    = 8;
   localparam int LAT_MAX = DEPTH * (SMAX + 1) + 1;

   logic CLK = 1'b0;
   logic RSTN = 1'b0;
   always #5 CLK = ~CLK;

   gf12_sram64_be_sched_if #(.ABITS(AW), .DWIDTH(DW)) bus ();

   logic          CE0, WE0, CE1;
   logic [AW-1:0] A0, A1;
   logic [DW-1:0] D0, WEM0, Q1;

   gf12_sram64_be_sched #(
      .ABITS(AW), .DWIDTH(DW), .BANK_LSB(BL),
      .WBUF_DEPTH(DEPTH), .STARVE_MAX(SMAX)
   ) dut (
      .CLK(CLK), .RSTN(RSTN), .req(bus),
      .CE0(CE0), .A0(A0), .D0(D0), .WE0(WE0), .WEM0(WEM0),
      .CE1(CE1), .A1(A1), .Q1(Q1)
   );

   // SRAM wrapper model: read wins a same-bank collision, write is lost.
   bit [DW-1:0] sram [2**AW];
   always @(posedge CLK) begin
      if (CE1)
         Q1 <= sram[A1];
      if (CE0 && WE0 && !(CE1 && A1[AW-1:BL] == A0[AW-1:BL]))
         sram[A0] <= (sram[A0] & ~WEM0) | (D0 & WEM0);
   end

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [DW-1:0] m;
      int            t;
   } wr_t;

   wr_t           wq[$];
   logic [DW-1:0] rq[$];
   bit [DW-1:0]   cm [2**AW];
   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   bit            prev_rf = 1'b0;

   task automatic chk(input string n, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", n, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] peek(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = cm[a];
      foreach (wq[i])
         if (wq[i].a == a)
            v = (v & ~wq[i].m) | (wq[i].d & wq[i].m);
      return v;
   endfunction

   function automatic bit pend_hit(input logic [AW-1:0] a);
      bit h;
      h = 1'b0;
      foreach (wq[i])
         if (wq[i].a == a)
            h = 1'b1;
      return h;
   endfunction

   // Monitor: samples mid-cycle, after inputs settle, before the next edge.
   always @(negedge CLK) begin
      #3;
      if (!RSTN) begin
         wq.delete();
         rq.delete();
         prev_rf = 1'b0;
      end else begin : mon
         bit  rf, wf;
         wr_t w;
         int  lat;
         rf = bus.rd_valid && bus.rd_ready;
         wf = bus.wr_valid && bus.wr_ready;
         cyc++;
         chk("rsp_timing", bus.rsp_valid, prev_rf);
         if (bus.rsp_valid) begin
            chk("rsp_expected", rq.size() != 0, 1);
            if (rq.size() != 0)
               chk("rsp_data", bus.rsp_data, rq.pop_front());
         end
         chk("wr_ready", bus.wr_ready, wq.size() < DEPTH);
         if (bus.rd_valid && pend_hit(bus.rd_addr))
            chk("raw_block", bus.rd_ready, 0);
         chk("ce1", CE1, rf);
         if (rf)
            chk("a1", A1, bus.rd_addr);
         if (CE0 && CE1)
            chk("bank_clash", A0[AW-1:BL] != A1[AW-1:BL], 1);
         if (CE0) begin
            chk("wr_expected", wq.size() != 0, 1);
            if (wq.size() != 0) begin
               w = wq.pop_front();
               chk("we0", WE0, 1);
               chk("a0", A0, w.a);
               chk("d0", D0, w.d);
               chk("wem0", WEM0, w.m);
               lat = cyc - w.t;
               chk("wr_lat_min", lat >= 1, 1);
               chk("wr_lat_max", lat <= LAT_MAX, 1);
               cm[w.a] = (cm[w.a] & ~w.m) | (w.d & w.m);
            end
         end
         if (rf)
            rq.push_back(peek(bus.rd_addr));
         if (wf) begin
            w.a = bus.wr_addr;
            w.d = bus.wr_data;
            w.m = bus.wr_mask;
            w.t = cyc;
            wq.push_back(w);
         end
         prev_rf = rf;
      end
   end

   task automatic step(input bit wv, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [DW-1:0] wm,
                       input bit rv, input logic [AW-1:0] ra,
                       output bit wf, output bit rf);
      @(negedge CLK);
      bus.wr_valid = wv;
      bus.wr_addr  = wa;
      bus.wr_data  = wd;
      bus.wr_mask  = wm;
      bus.rd_valid = rv;
      bus.rd_addr  = ra;
      #3;
      wf = wv && bus.wr_ready;
      rf = rv && bus.rd_ready;
   endtask

   task automatic idle();
      bit wf, rf;
      step(0, '0, '0, '0, 0, '0, wf, rf);
   endtask

   function automatic logic [AW-1:0] raddr();
      logic [1:0] b;
      logic [2:0] o;
      b = 2'($urandom_range(0, 3));
      o = 3'($urandom_range(0, 7));
      return {b, 10'b0, o};
   endfunction

   function automatic logic [DW-1:0] t5d(input int j);
      return {32'(32'hC0DE0000 + j), 32'(32'h5A5A0000 + j)};
   endfunction

   task automatic out_zero(input string n);
      chk({n, "_ce0"}, CE0, 0);
      chk({n, "_we0"}, WE0, 0);
      chk({n, "_a0"}, A0, 0);
      chk({n, "_d0"}, D0, 0);
      chk({n, "_wem0"}, WEM0, 0);
      chk({n, "_ce1"}, CE1, 0);
      chk({n, "_a1"}, A1, 0);
      chk({n, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({n, "_rsp_data"}, bus.rsp_data, 0);
      chk({n, "_wr_ready"}, bus.wr_ready, 1);
      chk({n, "_rd_ready"}, bus.rd_ready, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      bit            wf, rf, pw, pr;
      int            ri, ce0_at, nw;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd, wm;

      bus.wr_valid = 0;
      bus.wr_addr  = '0;
      bus.wr_data  = '0;
      bus.wr_mask  = '0;
      bus.rd_valid = 1;
      bus.rd_addr  = 15'h0005;
      repeat (2) @(negedge CLK);
      #3;
      out_zero("reset");

      @(negedge CLK);
      RSTN = 1'b1;
      #3;
      chk("first_cycle_rd_ready", bus.rd_ready, 0);

      // Simple write then readback
      step(1, 15'h0005, {8{8'hA5}}, '1, 0, '0, wf, rf);
      chk("t1_accept", wf, 1);
      chk("t1_no_bypass", CE0, 0);
      idle();
      chk("t1_ce0", CE0, 1);
      chk("t1_a0", A0, 15'h0005);
      chk("t1_d0", D0, {8{8'hA5}});
      chk("t1_wem0", WEM0, '1);
      idle();
      step(0, '0, '0, '0, 1, 15'h0005, wf, rf);
      chk("t1_rd_fire", rf, 1);
      idle();
      chk("t1_rsp_valid", bus.rsp_valid, 1);
      chk("t1_rsp_data", bus.rsp_data, {8{8'hA5}});

      // Starvation: continuous bank-1 reads against a bank-1 write
      step(1, 15'h2100, 64'h1111_2222_3333_4444, '1,
           1, 15'h2000, wf, rf);
      chk("t2_accept", wf & rf, 1);
      ri = 1;
      ce0_at = -1;
      for (int k = 1; k <= 14; k++) begin
         step(0, '0, '0, '0, 1, AW'(15'h2000 + ri), wf, rf);
         if (rf) ri++;
         if (CE0 && ce0_at < 0) begin
            ce0_at = k;
            chk("t2_force_rd_ready", bus.rd_ready, 0);
            chk("t2_a0", A0, 15'h2100);
         end else if (ce0_at > 0 && k == ce0_at + 1) begin
            chk("t2_resume", rf, 1);
         end
      end
      chk("t2_force_cycle", ce0_at, 9);
      chk("t2_reads", ri, 14);
      idle();

      // Read-after-write hazard on a buffered write
      step(1, 15'h0010, 64'hDEAD_BEEF_0BAD_F00D, '1,
           1, 15'h0000, wf, rf);
      chk("t3_accept", wf & rf, 1);
      step(0, '0, '0, '0, 1, 15'h0001, wf, rf);
      chk("t3_rd1", rf, 1);
      chk("t3_blocked", CE0, 0);
      step(0, '0, '0, '0, 1, 15'h0010, wf, rf);
      chk("t3_hazard", bus.rd_ready, 0);
      chk("t3_pop", CE0, 1);
      step(0, '0, '0, '0, 1, 15'h0010, wf, rf);
      chk("t3_rd_after", rf, 1);
      idle();
      chk("t3_rsp", bus.rsp_data, 64'hDEAD_BEEF_0BAD_F00D);

      // Different banks: read now, write next cycle, then parallel
      step(1, 15'h6000, 64'h6000, '1, 1, 15'h4000, wf, rf);
      chk("t4_ce1", CE1, 1);
      chk("t4_a1", A1, 15'h4000);
      chk("t4_ce0_wait", CE0, 0);
      step(1, 15'h6001, 64'h6001, '1, 1, 15'h4001, wf, rf);
      chk("t4_ce0", CE0, 1);
      chk("t4_a0", A0, 15'h6000);
      chk("t4_par1", CE1, 1);
      step(0, '0, '0, '0, 1, 15'h4002, wf, rf);
      chk("t4_par2", CE0 & CE1, 1);
      chk("t4_a0b", A0, 15'h6001);
      idle();

      // Fill the buffer with bank-0 writes under bank-0 reads
      nw = 0;
      for (int k = 0; k < 40; k++) begin
         step(nw < 4, AW'(15'h0200 + nw), t5d(nw), '1,
              1, AW'(15'h0100 + k), wf, rf);
         if (k == 3) chk("t5_fourth", wf, 1);
         if (k == 4) chk("t5_full", bus.wr_ready, 0);
         if (wf) nw++;
      end
      repeat (3) idle();
      chk("t5_drained", wq.size(), 0);
      for (int j = 0; j < 4; j++) begin
         step(0, '0, '0, '0, 1, AW'(15'h0200 + j), wf, rf);
         idle();
         chk("t5_readback", bus.rsp_data, t5d(j));
      end

      // Reset with buffered writes and a read in flight
      step(1, 15'h0300, 64'h300, '1, 1, 15'h0100, wf, rf);
      step(1, 15'h0301, 64'h301, '1, 1, 15'h0101, wf, rf);
      step(1, 15'h0302, 64'h302, '1, 1, 15'h0102, wf, rf);
      @(negedge CLK);
      bus.wr_valid = 0;
      bus.rd_valid = 1;
      bus.rd_addr  = 15'h0103;
      RSTN = 1'b0;
      #1;
      out_zero("t6_reset");
      @(negedge CLK);
      RSTN = 1'b1;
      bus.rd_valid = 0;
      #3;
      chk("t6_rsp_quiet0", bus.rsp_valid, 0);
      chk("t6_ce0_quiet0", CE0, 0);
      idle();
      chk("t6_rsp_quiet1", bus.rsp_valid, 0);
      chk("t6_ce0_quiet1", CE0, 0);
      step(0, '0, '0, '0, 1, 15'h0300, wf, rf);
      chk("t6_rd_fire", rf, 1);
      idle();
      chk("t6_dropped", bus.rsp_data, 0);

      // Randomized traffic on a small address set
      pw = 0;
      pr = 0;
      wa = '0; wd = '0; wm = '0; ra = '0;
      for (int c = 0; c < 600; c++) begin
         if (!pw && $urandom_range(0, 99) < 55) begin
            pw = 1;
            wa = raddr();
            wd = {$urandom, $urandom};
            wm = $urandom_range(0, 1) ? '1 : {$urandom, $urandom};
         end
         if (!pr && $urandom_range(0, 99) < 60) begin
            pr = 1;
            ra = raddr();
         end
         step(pw, wa, wd, wm, pr, ra, wf, rf);
         if (wf) pw = 0;
         if (rf) pr = 0;
      end
      repeat (LAT_MAX + 5) idle();
      chk("final_wq_empty", wq.size(), 0);
      chk("final_rq_empty", rq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
